alu_selftest: RTL and testbench
===============================

ALU_SELFTEST -- requirements
Module: alu_selftest

Interface
REQ-001 SETTLE_CYC, default 2, SHALL set settle cycles between driving a vector and sampling p1; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 start  input  1  SHALL request one full sweep when sampled high in IDLE or DONE.
REQ-005 t1  output  1  SHALL drive ALU operand A, registered.
REQ-006 t2  output  1  SHALL drive ALU operand B, registered.
REQ-007 t3  output  2  SHALL drive ALU control ALUCtrl, registered.
REQ-008 p1  input  1  SHALL carry ALU result Res back from the device under test.
REQ-009 busy  output  1  SHALL be high in SETTLE and SAMPLE.
REQ-010 done  output  1  SHALL be high in DONE only.
REQ-011 pass  output  1  SHALL equal done AND (err_cnt == 0).
REQ-012 err_cnt  output  5  SHALL count mismatching vectors in the current or last sweep.
REQ-013 fail_vec  output  16  SHALL hold per-vector mismatch flags; bit i flags vector i.

Function
REQ-014 Vector index idx SHALL be 4 bits, {t3, t1, t2} = idx; sweep order SHALL be idx 0 to 15 ascending.
REQ-015 Golden result SHALL be: ALUCtrl 00 A&B; 01 A|B; 10 A^B; 11 ~(A|B).
REQ-016 States SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-017 IDLE or DONE with start=1: next state SETTLE, idx=0, settle counter=0, err_cnt=0, fail_vec=0.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle; at its closing edge p1 is compared with golden(idx); mismatch sets fail_vec[idx] and increments err_cnt.
REQ-020 SAMPLE with idx<15: idx increments, next state SETTLE; with idx==15: next state DONE.
REQ-021 t1/t2/t3 SHALL reflect current idx throughout SETTLE and SAMPLE, change only on the edge leaving SAMPLE, and hold the last value in DONE.
REQ-022 Each vector SHALL occupy SETTLE_CYC+1 cycles; done SHALL rise exactly 16*(SETTLE_CYC+1) cycles after the edge that sampled start.
REQ-023 start while busy SHALL be ignored with no effect on idx, counters or timing.
REQ-024 DONE SHALL hold done, pass, err_cnt and fail_vec stable until start or rst.
REQ-025 start in DONE SHALL begin a new sweep per REQ-017, clearing the previous results on the same edge.
REQ-026 err_cnt SHALL never wrap; maximum value is 16.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, idx=0, t1=0, t2=0, t3=00, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, from any state.
REQ-028 rst SHALL take priority over start on the same edge.
REQ-029 A reset in mid-sweep SHALL abandon the sweep; the next start SHALL begin at idx 0.

Verification
REQ-030 Correct ALU, SETTLE_CYC=2, start pulse -> done rises 48 cycles later; err_cnt=0, fail_vec=16'h0000, pass=1.
REQ-031 ALU output stuck at 0 -> err_cnt=7, fail_vec=16'h16E8, pass=0.
REQ-032 Monitor t3/t1/t2 at every SAMPLE -> exact sequence 0..15, each held 3 cycles.
REQ-033 start re-pulsed during vector 5 -> ignored; completion time and results identical to REQ-030.
REQ-034 rst asserted during vector 7 -> next cycle IDLE with all outputs zero; a new start gives results identical to REQ-030.
REQ-035 Stuck-at-0 sweep, then a correct ALU and start from DONE -> results clear on the start edge; the final result is err_cnt=0, pass=1.

Source files
------------

// File: rtl/alu_selftest.sv
// Built-in self-test sequencer for a 1-bit, 4-function ALU.
// Sweeps all 16 {ALUCtrl,A,B} vectors, checks Res against golden, reports.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request one full sweep (honoured in IDLE/DONE only)
//   t1, t2, t3        registered ALU operand A, operand B, ALUCtrl
//   p1                ALU result Res returned from the device under test
//   busy              high while a sweep is in progress
//   done, pass        sweep finished / finished with zero mismatches
//   err_cnt           number of mismatching vectors (0..16)
//   fail_vec          per-vector mismatch flags, bit i = vector i
module alu_selftest #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        t1,
    output logic        t2,
    output logic [1:0]  t3,
    input  logic        p1,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic [15:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYC - 1);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] scnt;
    logic       golden;
    logic       miss;

    // Golden result for the vector currently being applied.
    always_comb begin
        golden = 1'b0;
        unique case (1'b1)
            idx[3:2] == 2'b00: golden = idx[1] & idx[0];
            idx[3:2] == 2'b01: golden = idx[1] | idx[0];
            idx[3:2] == 2'b10: golden = idx[1] ^ idx[0];
            idx[3:2] == 2'b11: golden = ~(idx[1] | idx[0]);
        endcase
    end

    assign miss = (p1 != golden);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 4'd0;
            scnt     <= 4'd0;
            t1       <= 1'b0;
            t2       <= 1'b0;
            t3       <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 5'd0;
            fail_vec <= 16'h0000;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= SETTLE;
                        idx           <= 4'd0;
                        scnt          <= 4'd0;
                        {t3, t1, t2}  <= 4'd0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_cnt       <= 5'd0;
                        fail_vec      <= 16'h0000;
                    end
                end
                SETTLE: begin
                    if (scnt == LAST_SETTLE) begin
                        state <= SAMPLE;
                        scnt  <= 4'd0;
                    end else begin
                        scnt <= scnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (miss) begin
                        fail_vec[idx] <= 1'b1;
                        if (err_cnt != 5'd31) begin
                            err_cnt <= err_cnt + 5'd1;
                        end
                    end
                    if (idx == 4'd15) begin
                        // Operands stay on the last vector while in DONE.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == 5'd0) && !miss;
                    end else begin
                        state        <= SETTLE;
                        idx          <= idx + 4'd1;
                        {t3, t1, t2} <= idx + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_selftest.sv
// Bench for alu_selftest: behavioural ALU with injectable faults,
// cycle-level reference model, literal checks on known sweeps.
module tb_alu_selftest;

    localparam int S = 2;
    localparam int VC = S + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        t1;
    logic        t2;
    logic [1:0]  t3;
    logic        p1;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_cnt;
    logic [15:0] fail_vec;

    logic        stuck;
    logic [15:0] mask;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_selftest #(.SETTLE_CYC(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .t1       (t1),
        .t2       (t2),
        .t3       (t3),
        .p1       (p1),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_vec (fail_vec)
    );

    function automatic logic gold(input logic [3:0] v);
        logic a;
        logic b;
        a = v[1];
        b = v[0];
        case (v[3:2])
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // ALU under test: correct, stuck-at-0, or flipped on masked vectors.
    assign p1 = stuck ? 1'b0 : (gold({t3, t1, t2}) ^ mask[{t3, t1, t2}]);

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: time elapsed since the accepted start.
    bit        m_act;
    bit        m_done;
    int        m_c;
    bit [15:0] m_fv;
    bit        chk_en = 1'b0;

    function automatic bit vec_bad(input int v);
        if (stuck) return gold(4'(v)) == 1'b1;
        return mask[v];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act  = 1'b0;
            m_done = 1'b0;
            m_c    = 0;
            m_fv   = '0;
        end else if (!m_act && start) begin
            m_act  = 1'b1;
            m_done = 1'b0;
            m_c    = 0;
            m_fv   = '0;
        end else if (m_act) begin
            m_c++;
            if (m_c % VC == 0) begin
                if (vec_bad(m_c / VC - 1)) m_fv[m_c / VC - 1] = 1'b1;
                if (m_c == 16 * VC) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int ei;
        if (chk_en) begin
            ei = m_act ? (m_c / VC) : (m_done ? 15 : 0);
            check("busy", int'(busy), int'(m_act));
            check("done", int'(done), int'(m_done));
            check("pass", int'(pass), int'(m_done && m_fv == 0));
            check("err_cnt", int'(err_cnt), $countones(m_fv));
            check("fail_vec", int'(fail_vec), int'(m_fv));
            check("vector", int'({t3, t1, t2}), ei);
        end
    end

    // One sweep: start pulse, optional re-pulse / abort at cycle n.
    task automatic sweep(input int rp, input int ab, output int n);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        check("clear_err", int'(err_cnt), 0);
        check("clear_fv", int'(fail_vec), 0);
        check("busy_on", int'(busy), 1);
        while (!done && n < 400) begin
            if (n == ab) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                n = -1;
                return;
            end
            start = (n == rp);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("no_timeout", int'(n < 400), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"}, int'(err_cnt), 0);
        check({tag, "_fv"}, int'(fail_vec), 0);
        check({tag, "_t"}, int'({t3, t1, t2}), 0);
    endtask

    initial begin
        int n;
        int rp;
        int ab;
        rst   = 1'b1;
        start = 1'b0;
        stuck = 1'b0;
        mask  = 16'h0000;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        check_zero("reset");

        // Correct ALU.
        sweep(-1, -1, n);
        check("cycles_ok", n, 48);
        check("ok_err", int'(err_cnt), 0);
        check("ok_fv", int'(fail_vec), 16'h0000);
        check("ok_pass", int'(pass), 1);
        repeat (4) @(negedge clk);
        check("hold_done", int'(done), 1);

        // Stuck-at-0 ALU.
        stuck = 1'b1;
        sweep(-1, -1, n);
        check("cycles_s0", n, 48);
        check("s0_err", int'(err_cnt), 7);
        check("s0_fv", int'(fail_vec), 16'h16E8);
        check("s0_pass", int'(pass), 0);

        // Restart from DONE with a good ALU clears results.
        stuck = 1'b0;
        sweep(-1, -1, n);
        check("cycles_re", n, 48);
        check("re_err", int'(err_cnt), 0);
        check("re_pass", int'(pass), 1);

        // start re-pulsed during vector 5 is ignored.
        sweep(16, -1, n);
        check("cycles_rp", n, 48);
        check("rp_fv", int'(fail_vec), 16'h0000);
        check("rp_pass", int'(pass), 1);

        // Reset during vector 7 abandons the sweep.
        sweep(-1, 22, n);
        check_zero("abort");
        sweep(-1, -1, n);
        check("cycles_ab", n, 48);
        check("ab_pass", int'(pass), 1);

        // Reset wins over start on the same edge.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_zero("rst_prio");

        // Randomized fault masks, re-pulses and aborts.
        for (int k = 0; k < 14; k++) begin
            mask = 16'($urandom_range(0, 65535));
            if (k % 5 == 0) mask = 16'hFFFF;
            rp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 46)) : -1;
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 46)) : -1;
            sweep(rp, ab, n);
            if (ab < 0) begin
                check("rnd_cycles", n, 48);
                check("rnd_fv", int'(fail_vec), int'(mask));
                check("rnd_err", int'(err_cnt), $countones(mask));
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
